fir_sample_feeder: RTL and testbench
====================================

FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning input FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TAPS, default 4, meaning filter taps; TAPS-1 zero flush samples are appended per frame.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_data  input  17  sample written by the upstream source.
REQ-006 SHALL have port s_valid  input  1  s_data/s_last valid.
REQ-007 SHALL have port s_last  input  1  marks the final sample of a frame.
REQ-008 SHALL have port s_ready  output  1  FIFO can accept a write.
REQ-009 SHALL have port x_in  output  17  registered sample to the filter.
REQ-010 SHALL have port in_data_vld  output  1  registered qualifier for x_in.
REQ-011 SHALL have port busy  output  1  state is not IDLE.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of frame flush.
REQ-013 SHALL have port frame_len  output  8  data samples (flush excluded) in the most recently completed frame, saturating at 255.
REQ-014 SHALL have port underrun_cnt  output  8  STREAM cycles with FIFO empty, saturating at 255.

Function
REQ-015 SHALL store {s_last, s_data} in a DEPTH-entry FIFO; write occurs on an edge where s_valid && s_ready.
REQ-016 SHALL drive s_ready = !full combinationally; no write when full, even with a same-cycle pop.
REQ-017 SHALL implement states IDLE, STREAM, FLUSH, DONE.
REQ-018 IDLE: in_data_vld=0, x_in=0; go to STREAM on the edge where FIFO is non-empty; no pop in IDLE.
REQ-019 STREAM, FIFO non-empty: pop head; next edge x_in=head data, in_data_vld=1, frame sample counter +1 (saturating 255).
REQ-020 STREAM, FIFO empty: next edge x_in=0, in_data_vld=0, underrun_cnt +1 (saturating); stay in STREAM.
REQ-021 Popped entry with last=1: go to FLUSH on the same edge that drives that sample.
REQ-022 FLUSH: emit exactly TAPS-1 consecutive cycles of x_in=0, in_data_vld=1; no pops; writes still accepted.
REQ-023 After the last flush cycle, SHALL enter DONE: in_data_vld=0, x_in=0, frame_done=1 for exactly one cycle, frame_len loaded with frame counter, counter cleared; next state IDLE.
REQ-024 Latency: write at edge N into empty FIFO in IDLE -> in_data_vld=1 with that sample after edge N+2.
REQ-025 Back-to-back: with FIFO non-empty, STREAM SHALL emit one sample per cycle without bubbles.
REQ-026 Simultaneous push and pop when not full SHALL both occur; occupancy unchanged.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter range 0..DEPTH.
REQ-028 Single-sample frame (first sample has last=1) SHALL produce 1 data + TAPS-1 zeros; frame_len=1.

Reset
REQ-029 Reset SHALL asynchronously force: state IDLE, FIFO empty, x_in=0, in_data_vld=0, frame_done=0, frame_len=0, underrun_cnt=0, frame counter=0; s_ready=1 while reset held.
REQ-030 Reset mid-frame (STREAM or FLUSH) SHALL discard FIFO contents and partial frame; no frame_done pulse.

Verification
REQ-031 Write 7 samples 1..7 back-to-back, last on 7 -> x_in 1,2,...,7,0,0,0 with in_data_vld=1 on 10 consecutive cycles, then frame_done pulse, frame_len=7.
REQ-032 Write 9 samples without reading possible (block held in FLUSH of prior frame) -> s_ready low after 8th write; 9th held until a pop; no data lost or duplicated.
REQ-033 Write sample 5, wait 3 cycles, write 6 with last -> one cycle 5, in_data_vld=0 gaps counted in underrun_cnt (=3 or as timing dictates, checked against model), then 6,0,0,0.
REQ-034 Single sample 0x1FFFF with last -> x_in 0x1FFFF,0,0,0, frame_len=1.
REQ-035 Assert reset during FLUSH cycle 2 -> outputs zero immediately, no frame_done, busy=0, next frame starts cleanly with correct latency.
REQ-036 Frame of 300 samples -> frame_len=255 (saturated), all 300 samples plus 3 zeros emitted in order.

Source files
------------

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers framed samples in a FIFO and streams them to a FIR, appending TAPS-1 zero flush samples per frame
module fir_sample_feeder #(
  parameter int DEPTH = 8,
  parameter int TAPS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [16:0] x_in,
  output logic        in_data_vld,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_len,
  output logic [7:0]  underrun_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(TAPS) + 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  logic [17:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_state;
  logic [FW-1:0] r_flush;
  logic [7:0]    r_frame_cnt;
  logic [16:0]   r_x;
  logic          r_vld;
  logic [7:0]    r_frame_len;
  logic [7:0]    r_underrun;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [17:0]   w_head;
  assign w_empty      = r_count == '0;
  assign s_ready      = r_count != (AW+1)'(DEPTH);
  assign w_push       = s_valid && s_ready;
  assign w_pop        = (r_state == STREAM) && !w_empty;
  assign w_head       = r_mem[r_rd_ptr];
  assign busy         = r_state != IDLE;
  assign frame_done   = r_state == DONE;
  assign x_in         = r_x;
  assign in_data_vld  = r_vld;
  assign frame_len    = r_frame_len;
  assign underrun_cnt = r_underrun;
  // FIFO storage: entry is {last, data}; storage itself needs no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_last, s_data};
  end
  // FIFO pointers wrap naturally at DEPTH (power of two); push and pop may coincide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // Frame sequencer: registered sample output, flush run, per-frame length and underrun statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_flush     <= '0;
      r_frame_cnt <= '0;
      r_x         <= '0;
      r_vld       <= 1'b0;
      r_frame_len <= '0;
      r_underrun  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_x   <= '0;
          r_vld <= 1'b0;
          if (!w_empty) r_state <= STREAM;
        end
        STREAM: begin
          if (w_pop) begin
            r_x         <= w_head[16:0];
            r_vld       <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 8'(r_frame_cnt != 8'hFF);
            if (w_head[17]) begin
              r_state <= FLUSH;
              r_flush <= '0;
            end
          end else begin
            r_x        <= '0;
            r_vld      <= 1'b0;
            r_underrun <= r_underrun + 8'(r_underrun != 8'hFF);
          end
        end
        FLUSH: begin
          r_x <= '0;
          if (r_flush == FW'(TAPS - 1)) begin
            r_vld       <= 1'b0;
            r_state     <= DONE;
            r_frame_len <= r_frame_cnt;
            r_frame_cnt <= '0;
          end else begin
            r_vld   <= 1'b1;
            r_flush <= r_flush + FW'(1);
          end
        end
        default: begin
          r_x     <= '0;
          r_vld   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: vector table, directed corner sequences and random traffic against a queue-based frame model
module tb_fir_sample_feeder;
  localparam int DEPTH = 8;
  localparam int TAPS  = 4;
  localparam int M_IDLE = 0, M_STREAM = 1, M_FLUSH = 2, M_DONE = 3;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [16:0] x_in;
  logic        in_data_vld;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_len;
  logic [7:0]  underrun_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  bit saw_full = 0;
  int first_full_k = -1;
  logic [17:0] mq[$];
  int m_mode = M_IDLE;
  int m_zeros = 0;
  int m_cnt = 0;
  int m_len = 0;
  int m_und = 0;
  logic [16:0] m_x = '0;
  logic m_v = 1'b0;
  typedef struct {
    bit          v;
    bit          l;
    logic [16:0] d;
    bit          ev;
    logic [16:0] ex;
    bit          efd;
  } vec_t;
  vec_t tab[14];
  always #5 clk = ~clk;
  fir_sample_feeder #(.DEPTH(DEPTH), .TAPS(TAPS)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .x_in(x_in), .in_data_vld(in_data_vld), .busy(busy),
    .frame_done(frame_done), .frame_len(frame_len), .underrun_cnt(underrun_cnt)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: frames move through a queue; each popped frame yields its samples, TAPS-1 zeros, then one done cycle
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_mode = M_IDLE; m_zeros = 0; m_cnt = 0; m_len = 0; m_und = 0; m_x = '0; m_v = 1'b0;
    end else begin
      logic [17:0] e;
      bit acc;
      acc = s_valid && (mq.size() < DEPTH);
      if (m_mode == M_IDLE) begin
        m_x = '0; m_v = 1'b0;
        if (mq.size() > 0) m_mode = M_STREAM;
      end else if (m_mode == M_STREAM) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          m_x = e[16:0]; m_v = 1'b1;
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          if (e[17]) begin m_mode = M_FLUSH; m_zeros = TAPS - 1; end
        end else begin
          m_x = '0; m_v = 1'b0;
          m_und = (m_und < 255) ? m_und + 1 : 255;
        end
      end else if (m_mode == M_FLUSH) begin
        m_x = '0;
        if (m_zeros > 0) begin m_v = 1'b1; m_zeros--; end
        else begin m_v = 1'b0; m_mode = M_DONE; m_len = m_cnt; m_cnt = 0; end
      end else begin
        m_x = '0; m_v = 1'b0; m_mode = M_IDLE;
      end
      if (acc) mq.push_back({s_last, s_data});
    end
  end
  // Every cycle compare all outputs with the model, away from the rising edge
  always @(negedge clk) begin
    chk("x_in", 32'(x_in), 32'(m_x));
    chk("in_data_vld", 32'(in_data_vld), 32'(m_v));
    chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
    chk("frame_done", 32'(frame_done), 32'(m_mode == M_DONE));
    chk("frame_len", 32'(frame_len), 32'(m_len));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_und));
    chk("s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
  end
  task automatic wr(input logic [16:0] d, input bit l);
    int t = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && t < 200) begin
      saw_full = 1;
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_timeout: s_ready stayed 0, required 1");
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
  endtask
  task automatic drain();
    int t = 0;
    while (!(m_mode == M_IDLE && mq.size() == 0 && !busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: busy=%0b, required 0", busy);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_fd();
    int t = 0;
    while (!frame_done && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_done_timeout: frame_done=0, required 1");
    end
  endtask
  initial begin
    int und0;
    int t;
    for (int i = 0; i < 14; i++)
      tab[i] = '{v: (i < 7), l: (i == 6), d: (i < 7) ? 17'(i + 1) : 17'd0,
                 ev: (i >= 2 && i <= 11), ex: (i >= 2 && i <= 8) ? 17'(i - 1) : 17'd0, efd: (i == 12)};
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_x", 32'(x_in), 32'd0);
    chk("rst_len", 32'(frame_len), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    // Seven-sample frame, one row per clock edge
    for (int i = 0; i < 14; i++) begin
      s_valid = tab[i].v; s_last = tab[i].l; s_data = tab[i].d;
      @(posedge clk);
      @(negedge clk);
      chk("tab_vld", 32'(in_data_vld), 32'(tab[i].ev));
      chk("tab_x", 32'(x_in), 32'(tab[i].ex));
      chk("tab_fd", 32'(frame_done), 32'(tab[i].efd));
    end
    chk("tab_len", 32'(frame_len), 32'd7);
    chk("tab_und", 32'(underrun_cnt), 32'd0);
    drain();
    // Single-sample frames pile up while the block flushes; FIFO must fill and stall the tenth write
    for (int k = 0; k < 10; k++) begin
      saw_full = 0;
      wr(17'(100 + k), 1'b1);
      if (saw_full && first_full_k < 0) first_full_k = k;
    end
    chk("first_full_write", 32'(first_full_k), 32'd9);
    drain();
    // Gap between two samples of one frame produces underrun cycles
    und0 = int'(underrun_cnt);
    wr(17'd5, 1'b0);
    repeat (3) @(negedge clk);
    wr(17'd6, 1'b1);
    drain();
    chk("underrun_delta", 32'(int'(underrun_cnt) - und0), 32'd2);
    // Full-scale single-sample frame
    wr(17'h1FFFF, 1'b1);
    wait_fd();
    chk("single_len", 32'(frame_len), 32'd1);
    drain();
    // Reset during the second flush cycle
    wr(17'd1, 1'b0);
    wr(17'd2, 1'b1);
    t = 0;
    while (!(in_data_vld && x_in == 17'd2) && t < 100) begin @(negedge clk); t++; end
    chk("reach_last", 32'(x_in), 32'd2);
    repeat (2) @(negedge clk);
    chk("in_flush2", 32'(in_data_vld), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(in_data_vld), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_fd", 32'(frame_done), 32'd0);
    chk("mid_rst_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    s_valid = 1'b1; s_data = 17'h55; s_last = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    chk("lat_edge1", 32'(in_data_vld), 32'd0);
    @(negedge clk);
    chk("lat_edge2", 32'(in_data_vld), 32'd0);
    @(negedge clk);
    chk("lat_vld", 32'(in_data_vld), 32'd1);
    chk("lat_x", 32'(x_in), 32'h55);
    drain();
    // Long frame saturates the length counter
    for (int k = 0; k < 300; k++) wr(17'(k + 1), k == 299);
    wait_fd();
    chk("long_len", 32'(frame_len), 32'd255);
    drain();
    // Random traffic with random frame boundaries
    repeat (2000) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data = 17'($urandom);
      s_last = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
    wr(17'd0, 1'b1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
